scroll_display_ctrl: RTL and testbench

- Scheduler and sequencer for the 8-digit seven-segment display path.
- Holds a writable message buffer of up to 16 hex nibbles and scrolls it across the digits at a programmable step rate, in either direction.
- Time-multiplexes the digits at a programmable scan rate.
- Produces the digit index (drives the anode decoder) and the nibble for that digit (drives the cathode decoder). Replaces fixed-constant flip-flop loading with a runtime-loadable, start/stop-controlled scroller.

---
 rtl/scroll_display_ctrl.sv | 158 +++++++++++++++
 tb/tb_scroll_display_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/scroll_display_ctrl.sv
// Scrolling scheduler for an 8-digit seven-segment display: message buffer,
// scan multiplexing and start/stop/direction-controlled scrolling.
module scroll_display_ctrl #(
  parameter int SCAN_DIV = 100000,
  parameter int STEP_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [4:0] msg_len,
  input  logic       start,
  input  logic       stop,
  input  logic       direction,
  output logic [2:0] digit_sel,
  output logic [3:0] digit_val,
  output logic [3:0] offset,
  output logic       busy,
  output logic       wrap
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_TC = SCAN_W'(SCAN_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_TC = STEP_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        msg_q [16];
  logic [3:0]        msg_d [16];
  logic [4:0]        len_q, len_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [2:0]        digit_sel_q, digit_sel_d;
  logic [3:0]        digit_val_q, digit_val_d;
  logic [3:0]        offset_q, offset_d;
  logic              busy_q, busy_d;
  logic              wrap_q, wrap_d;

  logic              scan_tc;
  logic              step_tc;
  logic [4:0]        len_clamp;
  logic [3:0]        len_m1;
  logic [3:0]        off_next;
  logic              off_wrap;
  logic [4:0]        idx_sum;
  logic [3:0]        idx;

  always_comb begin
    len_clamp = (msg_len == 5'd0 || msg_len > 5'd16) ? 5'd16 : msg_len;
    len_m1    = 4'(len_q - 5'd1);
    if (!direction) begin
      off_wrap = (offset_q == len_m1);
      off_next = off_wrap ? 4'd0 : offset_q + 4'd1;
    end else begin
      off_wrap = (offset_q == 4'd0);
      off_next = off_wrap ? len_m1 : offset_q - 4'd1;
    end
  end

  always_comb begin
    msg_d = msg_q;
    if (wr_en) msg_d[wr_addr] = wr_data;

    scan_tc     = (scan_cnt_q == SCAN_TC);
    scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + 1'b1;
    digit_sel_d = scan_tc ? digit_sel_q + 3'd1 : digit_sel_q;

    step_tc    = (step_cnt_q == STEP_TC);
    state_d    = state_q;
    len_d      = len_q;
    offset_d   = offset_q;
    step_cnt_d = step_cnt_q;
    wrap_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        offset_d   = 4'd0;
        step_cnt_d = '0;
        if (!stop && start) begin
          state_d = RUN;
          len_d   = len_clamp;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = HOLD;
        end else if (step_tc) begin
          step_cnt_d = '0;
          offset_d   = off_next;
          wrap_d     = off_wrap;
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (stop) begin
          state_d    = IDLE;
          offset_d   = 4'd0;
          step_cnt_d = '0;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d    = IDLE;
        offset_d   = 4'd0;
        step_cnt_d = '0;
      end
    endcase

    busy_d = (state_d == RUN);

    // Look up with next-cycle values so digit_val stays aligned with digit_sel
    idx_sum     = {1'b0, offset_d} + {2'b00, digit_sel_d};
    idx         = 4'(idx_sum % len_d);
    digit_val_d = msg_d[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      msg_q       <= '{default: '0};
      len_q       <= 5'd8;
      scan_cnt_q  <= '0;
      step_cnt_q  <= '0;
      digit_sel_q <= 3'd0;
      digit_val_q <= 4'd0;
      offset_q    <= 4'd0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      len_q       <= len_d;
      scan_cnt_q  <= scan_cnt_d;
      step_cnt_q  <= step_cnt_d;
      digit_sel_q <= digit_sel_d;
      digit_val_q <= digit_val_d;
      offset_q    <= offset_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
    end
  end

  assign digit_sel = digit_sel_q;
  assign digit_val = digit_val_q;
  assign offset    = offset_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Directed bench for scroll_display_ctrl with SCAN_DIV=2, STEP_DIV=16.
// Inputs change and outputs are sampled on the falling edge.
module tb_scroll_display_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic [4:0] msg_len;
  logic       start;
  logic       stop;
  logic       direction;
  logic [2:0] digit_sel;
  logic [3:0] digit_val;
  logic [3:0] offset;
  logic       busy;
  logic       wrap;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [3:0] mbuf [16];

  localparam logic [3:0] PAT [8] = '{4'h2, 4'h0, 4'h2, 4'h2,
                                     4'hE, 4'hE, 4'h1, 4'h5};

  scroll_display_ctrl #(
    .SCAN_DIV(2),
    .STEP_DIV(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .msg_len  (msg_len),
    .start    (start),
    .stop     (stop),
    .direction(direction),
    .digit_sel(digit_sel),
    .digit_val(digit_val),
    .offset   (offset),
    .busy     (busy),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Digit index advances every 2 clocks from reset release
  task automatic chk_disp(input int off, input int len);
    int s;
    s = (cyc / 2) % 8;
    chk("digit_sel", digit_sel, s);
    chk("digit_val", digit_val, mbuf[(off + s) % len]);
  endtask

  task automatic run_span(input int n, input int off0, input int off1,
                          input bit wr_end, input int len);
    int o;
    for (int k = 1; k <= n; k++) begin
      tick();
      o = (k == n) ? off1 : off0;
      chk("offset", offset, o);
      chk("wrap", wrap, (k == n) ? int'(wr_end) : 0);
      chk("busy", busy, 1);
      chk_disp(o, len);
    end
  endtask

  task automatic chk_reset();
    chk("rst_sel", digit_sel, 0);
    chk("rst_val", digit_val, 0);
    chk("rst_off", offset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mbuf[i] = 4'h0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    msg_len = 5'd0; start = 1'b0; stop = 1'b0; direction = 1'b0;
    repeat (3) tick();
    chk_reset();
    reset = 1'b0;
    cyc = 0;

    // Idle scanning with an empty buffer
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_off", offset, 0);
      chk_disp(0, 8);
    end

    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = PAT[i];
      mbuf[i] = PAT[i];
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_disp(0, 8);
      if ((cyc / 2) % 8 == 3) chk("dig3", digit_val, 2);
      if ((cyc / 2) % 8 == 4) chk("dig4", digit_val, 14);
    end

    // Start with length 9, scroll left through a full wrap
    msg_len = 5'd9; direction = 1'b0; start = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 4'h2; mbuf[8] = 4'h2;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_off", offset, 0);
    chk_disp(0, 9);
    for (int i = 0; i < 9; i++) run_span(16, i, (i + 1) % 9, i == 8, 9);

    direction = 1'b1;
    run_span(16, 0, 8, 1'b1, 9);
    run_span(16, 8, 7, 1'b0, 9);

    // Pause after 5 counted cycles; 11 remain after resume
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pre_off", offset, 7);
      chk("pre_busy", busy, 1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("hold_busy", busy, 0);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("hold_off", offset, 7);
      chk("hold_busy", busy, 0);
      chk_disp(7, 9);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("resume_busy", busy, 1);
    chk("resume_off", offset, 7);
    run_span(11, 7, 6, 1'b0, 9);

    stop = 1'b1;
    tick();
    chk("hold2_off", offset, 6);
    chk("hold2_busy", busy, 0);
    tick();
    stop = 1'b0;
    chk("idle_off0", offset, 0);
    chk_disp(0, 9);

    // Stop dominates start in IDLE
    start = 1'b1; stop = 1'b1;
    repeat (3) tick();
    chk("both_busy", busy, 0);
    chk("both_off", offset, 0);
    stop = 1'b0; msg_len = 5'd0; direction = 1'b0;
    tick();
    start = 1'b0;
    chk("len16_busy", busy, 1);
    for (int i = 0; i < 16; i++) run_span(16, i, (i + 1) % 16, i == 15, 16);

    repeat (7) tick();
    reset = 1'b1;
    tick();
    chk_reset();
    for (int i = 0; i < 16; i++) mbuf[i] = 4'h0;
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("post_busy", busy, 0);
      chk("post_off", offset, 0);
      chk_disp(0, 8);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
